// File: rtl/ipsxe_floating_point_div_mul_v1_0_pkg.sv
// Shared field widths, constants, operand classes and flag bundle for the
// reciprocal-multiply back end of the LUT divider.
package ipsxe_floating_point_div_mul_v1_0_pkg;

    localparam int unsigned FLT_WIDTH  = 32;
    localparam int unsigned EXP_WIDTH  = 8;
    localparam int unsigned FRAC_WIDTH = 23;
    localparam int unsigned MANT_WIDTH = FRAC_WIDTH + 1;
    localparam int unsigned PROD_WIDTH = 2 * MANT_WIDTH;
    localparam int unsigned EXPW       = EXP_WIDTH + 2;
    localparam int unsigned EXP_BIAS   = 127;
    localparam int unsigned EXP_INF    = (1 << EXP_WIDTH) - 1;

    localparam logic [FLT_WIDTH-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_NAN  = 2'd1,
        SP_INF  = 2'd2,
        SP_ZERO = 2'd3
    } special_e;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic divide_by_zero;
        logic invalid_op;
    } fp_flags_t;

    // Denormals fold into ZERO; the divider never produces or consumes them.
    function automatic fp_class_e fp_classify(input logic [FLT_WIDTH-1:0] x);
        logic [EXP_WIDTH-1:0]  e;
        logic [FRAC_WIDTH-1:0] f;
        e = x[FLT_WIDTH-2 -: EXP_WIDTH];
        f = x[FRAC_WIDTH-1:0];
        if (e == '0)
            return CLS_ZERO;
        if (e == '1)
            return (f == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_div_mul_norm_v1_0.sv
// S3 combinational normalize / round / range-check / pack of the 48-bit product.
// IPSXE_FLOATING_POINT_DIV_MUL_RNE_EN selects round-to-nearest-even, else truncation.
module ipsxe_floating_point_div_mul_norm_v1_0
    import ipsxe_floating_point_div_mul_v1_0_pkg::*;
(
    input  logic                   sign,
    input  logic signed [EXPW-1:0] exp_in,
    input  logic [PROD_WIDTH-1:0]  prod,
    output logic [FLT_WIDTH-1:0]   result,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned MANT_EXT = MANT_WIDTH + 1;

    logic                   hi;
    logic [MANT_WIDTH-1:0]  mant;
    logic [MANT_WIDTH-1:0]  mant_fin;
    logic signed [EXPW-1:0] exp_fin;
    logic                   unused_bits;

    // Product lies in [1,4); bit 47 set means one extra exponent step.
    assign hi   = prod[PROD_WIDTH-1];
    assign mant = hi ? prod[PROD_WIDTH-1 -: MANT_WIDTH] : prod[PROD_WIDTH-2 -: MANT_WIDTH];

`ifdef IPSXE_FLOATING_POINT_DIV_MUL_RNE_EN
    logic                guard;
    logic                rnd;
    logic                sticky;
    logic                round_up;
    logic [MANT_EXT-1:0] mant_rnd;

    assign guard    = hi ? prod[MANT_WIDTH-1] : prod[MANT_WIDTH-2];
    assign rnd      = hi ? prod[MANT_WIDTH-2] : prod[MANT_WIDTH-3];
    assign sticky   = hi ? (|prod[MANT_WIDTH-3:0]) : (|prod[MANT_WIDTH-4:0]);
    assign round_up = guard & (rnd | sticky | mant[0]);
    assign mant_rnd = MANT_EXT'(mant) + MANT_EXT'(round_up);

    // A carry out of the rounder leaves 1.000..0 one binade higher.
    assign mant_fin    = mant_rnd[MANT_WIDTH] ? mant_rnd[MANT_WIDTH:1] : mant_rnd[MANT_WIDTH-1:0];
    assign exp_fin     = exp_in + $signed(EXPW'(hi)) + $signed(EXPW'(mant_rnd[MANT_WIDTH]));
    assign unused_bits = mant_fin[MANT_WIDTH-1];
`else
    assign mant_fin    = mant;
    assign exp_fin     = exp_in + $signed(EXPW'(hi));
    assign unused_bits = ^{mant_fin[MANT_WIDTH-1], prod[MANT_WIDTH-2:0]};
`endif

    always_comb begin
        overflow  = 1'b0;
        underflow = 1'b0;
        result    = {sign, exp_fin[EXP_WIDTH-1:0], mant_fin[FRAC_WIDTH-1:0]};
        if (exp_fin >= $signed(EXPW'(EXP_INF))) begin
            overflow = 1'b1;
            result   = {sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
        end else if (exp_fin <= $signed(EXPW'(0))) begin
            underflow = 1'b1;
            result    = {sign, {(FLT_WIDTH-1){1'b0}}};
        end
    end

endmodule

// File: rtl/ipsxe_floating_point_div_mul_v1_0.sv
// Divider back end: q = a * (1/b), 3-stage IEEE-754 single multiply with special merge.
// IPSXE_FLOATING_POINT_DIV_MUL_RNE_EN enables round-to-nearest-even in S3 (default truncate).
module ipsxe_floating_point_div_mul_v1_0
    import ipsxe_floating_point_div_mul_v1_0_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_aclken,
    input  logic                 i_tvalid,
    input  logic [FLT_WIDTH-1:0] i_op_a,
    input  logic [FLT_WIDTH-1:0] i_reci,
    input  logic                 i_reci_dbz,
    input  logic                 i_reci_uf,
    output logic [FLT_WIDTH-1:0] o_result,
    output logic                 o_q_valid,
    output logic                 o_overflow,
    output logic                 o_underflow,
    output logic                 o_divide_by_zero,
    output logic                 o_invalid_op
);

    fp_class_e cls_a;
    fp_class_e cls_r;
    special_e  sp_c;
    fp_flags_t sp_flags_c;

    logic                   s1_valid;
    logic                   s1_sign;
    logic signed [EXPW-1:0] s1_exp;
    logic [MANT_WIDTH-1:0]  s1_mant_a;
    logic [MANT_WIDTH-1:0]  s1_mant_r;
    special_e               s1_sp;
    fp_flags_t              s1_flags;

    logic                   s2_valid;
    logic                   s2_sign;
    logic signed [EXPW-1:0] s2_exp;
    logic [PROD_WIDTH-1:0]  s2_prod;
    special_e               s2_sp;
    fp_flags_t              s2_flags;

    logic [FLT_WIDTH-1:0]   norm_result;
    logic                   norm_ovf;
    logic                   norm_uf;
    logic [FLT_WIDTH-1:0]   res_c;
    fp_flags_t              flags_c;

    assign cls_a = fp_classify(i_op_a);
    assign cls_r = fp_classify(i_reci);

    // Special-case decode in priority order; SP_NONE falls through to arithmetic.
    always_comb begin
        sp_c       = SP_NONE;
        sp_flags_c = '0;
        if (cls_a == CLS_NAN || (i_reci_dbz && cls_a == CLS_ZERO) ||
            (cls_a == CLS_INF && cls_r == CLS_ZERO)) begin
            sp_c                  = SP_NAN;
            sp_flags_c.invalid_op = 1'b1;
        end else if (i_reci_dbz) begin
            sp_c                      = SP_INF;
            sp_flags_c.divide_by_zero = 1'b1;
        end else if (cls_a == CLS_INF) begin
            sp_c = SP_INF;
        end else if (cls_a == CLS_ZERO || cls_r == CLS_ZERO || i_reci_uf) begin
            sp_c                 = SP_ZERO;
            sp_flags_c.underflow = i_reci_uf & (cls_a != CLS_ZERO);
        end
    end

    // S1 unpack / exponent add, S2 mantissa multiply.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_mant_a <= '0;
            s1_mant_r <= '0;
            s1_sp     <= SP_NONE;
            s1_flags  <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_exp    <= '0;
            s2_prod   <= '0;
            s2_sp     <= SP_NONE;
            s2_flags  <= '0;
        end else if (i_aclken) begin
            s1_valid  <= i_tvalid;
            s1_sign   <= i_op_a[FLT_WIDTH-1] ^ i_reci[FLT_WIDTH-1];
            s1_exp    <= $signed(EXPW'(i_op_a[FLT_WIDTH-2 -: EXP_WIDTH]))
                       + $signed(EXPW'(i_reci[FLT_WIDTH-2 -: EXP_WIDTH]))
                       - $signed(EXPW'(EXP_BIAS));
            s1_mant_a <= {1'b1, i_op_a[FRAC_WIDTH-1:0]};
            s1_mant_r <= {1'b1, i_reci[FRAC_WIDTH-1:0]};
            s1_sp     <= sp_c;
            s1_flags  <= sp_flags_c;
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_exp    <= s1_exp;
            s2_prod   <= PROD_WIDTH'(s1_mant_a) * PROD_WIDTH'(s1_mant_r);
            s2_sp     <= s1_sp;
            s2_flags  <= s1_flags;
        end
    end

    ipsxe_floating_point_div_mul_norm_v1_0 u_norm (
        .sign      (s2_sign),
        .exp_in    (s2_exp),
        .prod      (s2_prod),
        .result    (norm_result),
        .overflow  (norm_ovf),
        .underflow (norm_uf)
    );

    // Specials override the arithmetic result and carry their own flags.
    always_comb begin
        res_c             = norm_result;
        flags_c           = '0;
        flags_c.overflow  = norm_ovf;
        flags_c.underflow = norm_uf;
        case (s2_sp)
            SP_NAN: begin
                res_c   = QNAN;
                flags_c = s2_flags;
            end
            SP_INF: begin
                res_c   = {s2_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
                flags_c = s2_flags;
            end
            SP_ZERO: begin
                res_c   = {s2_sign, {(FLT_WIDTH-1){1'b0}}};
                flags_c = s2_flags;
            end
            default: ;
        endcase
    end

    // S3 output register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_result         <= '0;
            o_q_valid        <= 1'b0;
            o_overflow       <= 1'b0;
            o_underflow      <= 1'b0;
            o_divide_by_zero <= 1'b0;
            o_invalid_op     <= 1'b0;
        end else if (i_aclken) begin
            o_result         <= res_c;
            o_q_valid        <= s2_valid;
            o_overflow       <= flags_c.overflow;
            o_underflow      <= flags_c.underflow;
            o_divide_by_zero <= flags_c.divide_by_zero;
            o_invalid_op     <= flags_c.invalid_op;
        end
    end

endmodule

// File: tb/tb_ipsxe_floating_point_div_mul_v1_0.sv
// Scoreboard bench for the reciprocal-multiply back end: directed corner cases,
// a stalled stream, mid-flight reset and randomized traffic against a reference model.
module tb_ipsxe_floating_point_div_mul_v1_0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aclken = 1'b0;
    logic        tvalid = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] reci = '0;
    logic        reci_dbz = 1'b0;
    logic        reci_uf = 1'b0;
    logic [31:0] o_result;
    logic        o_q_valid;
    logic        o_overflow;
    logic        o_underflow;
    logic        o_divide_by_zero;
    logic        o_invalid_op;

    always #5 clk = ~clk;

    ipsxe_floating_point_div_mul_v1_0 dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_aclken         (aclken),
        .i_tvalid         (tvalid),
        .i_op_a           (op_a),
        .i_reci           (reci),
        .i_reci_dbz       (reci_dbz),
        .i_reci_uf        (reci_uf),
        .o_result         (o_result),
        .o_q_valid        (o_q_valid),
        .o_overflow       (o_overflow),
        .o_underflow      (o_underflow),
        .o_divide_by_zero (o_divide_by_zero),
        .o_invalid_op     (o_invalid_op)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;   // {overflow, underflow, divide_by_zero, invalid_op}
        int          tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        front;
    int          tests = 0;
    int          fails = 0;
    int          ecnt = 0;
    logic        upd = 1'b0;
    logic        rst_seen = 1'b0;
    logic        started = 1'b0;
    logic [31:0] cur_res = '0;
    logic [3:0]  cur_flg = '0;
    logic [36:0] last_out = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact integer product of the significands, then scale/round/range-check.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] r,
                                          input logic dbz, input logic uf);
        logic            s;
        int              ea;
        int              er;
        int              sh;
        int              e;
        logic            a_zero;
        logic            a_inf;
        logic            a_nan;
        logic            r_zero;
        longint unsigned p;
        longint unsigned q;
        s      = a[31] ^ r[31];
        ea     = int'(a[30:23]);
        er     = int'(r[30:23]);
        a_zero = (ea == 0);
        a_inf  = (ea == 255) && (a[22:0] == 23'h0);
        a_nan  = (ea == 255) && (a[22:0] != 23'h0);
        r_zero = (er == 0);
        if (a_nan || (dbz && a_zero) || (a_inf && r_zero))
            return {4'b0001, 32'h7FC0_0000};
        if (dbz)
            return {4'b0010, s, 8'hFF, 23'h0};
        if (a_inf)
            return {4'b0000, s, 8'hFF, 23'h0};
        if (a_zero || r_zero || uf)
            return {1'b0, (uf && !a_zero), 2'b00, s, 31'h0};
        p  = 64'({1'b1, a[22:0]}) * 64'({1'b1, r[22:0]});
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        q  = p >> sh;
        e  = ea + er - 127 + (sh - 23);
`ifdef IPSXE_FLOATING_POINT_DIV_MUL_RNE_EN
        begin
            longint unsigned rem;
            longint unsigned half;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0]))
                q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
`endif
        if (e >= 255)
            return {4'b1000, s, 8'hFF, 23'h0};
        if (e <= 0)
            return {4'b0100, s, 31'h0};
        return {4'b0000, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_a();
        int unsigned k;
        logic        sg;
        logic [22:0] fr;
        k  = $urandom_range(0, 31);
        sg = 1'($urandom_range(0, 1));
        fr = 23'($urandom);
        case (k)
            0:       return {sg, 8'h00, 23'h0};
            1:       return {sg, 8'hFF, 23'h0};
            2:       return {sg, 8'hFF, fr | 23'h1};
            3:       return {sg, 8'h00, fr | 23'h1};
            4, 5, 6, 7, 8, 9, 10, 11:
                     return {sg, 8'($urandom_range(100, 154)), fr};
            12, 13:  return {sg, 8'h01, fr};
            14, 15:  return {sg, 8'hFE, fr};
            default: return {sg, 8'($urandom_range(1, 254)), fr};
        endcase
    endfunction

    function automatic logic [31:0] rand_r();
        int unsigned k;
        logic        sg;
        logic [22:0] fr;
        k  = $urandom_range(0, 15);
        sg = 1'($urandom_range(0, 1));
        fr = 23'($urandom);
        if (k == 0)
            return {sg, 8'h00, fr};
        if (k < 10)
            return {sg, 8'($urandom_range(100, 154)), fr};
        return {sg, 8'($urandom_range(1, 254)), fr};
    endfunction

    // Capture side: an enabled edge with tvalid registers one expected result.
    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            sb.delete();
            rst_seen <= 1'b1;
            upd      <= 1'b0;
        end else begin
            rst_seen <= 1'b0;
            upd      <= aclken;
            if (aclken) begin
                ecnt <= ecnt + 1;
                if (tvalid)
                    sb.push_back('{res: cur_res, flg: cur_flg, tag: ecnt + 1});
            end
        end
    end

    // Monitor: compares each new output, checks held outputs during stalls.
    always @(negedge clk) begin
        if (started) begin
            if (rst_seen) begin
                check("reset_outputs",
                      {o_q_valid, o_overflow, o_underflow, o_divide_by_zero, o_invalid_op, o_result}, 64'h0);
            end else if (upd) begin
                if (o_q_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 64'(o_result), 64'hDEAD_BEEF_DEAD_BEEF);
                    end else begin
                        front = sb.pop_front();
                        check("result", 64'(o_result), 64'(front.res));
                        check("flags", 64'({o_overflow, o_underflow, o_divide_by_zero, o_invalid_op}),
                              64'(front.flg));
                        check("latency", 64'(ecnt), 64'(front.tag + 2));
                    end
                end else if (sb.size() > 0 && sb[0].tag + 2 <= ecnt) begin
                    front = sb.pop_front();
                    check("missing_valid", 64'(o_q_valid), 64'h1);
                end
            end else begin
                check("stall_hold",
                      64'({o_q_valid, o_overflow, o_underflow, o_divide_by_zero, o_invalid_op, o_result}),
                      64'(last_out));
            end
            last_out <= {o_q_valid, o_overflow, o_underflow, o_divide_by_zero, o_invalid_op, o_result};
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] r, input logic dbz,
                        input logic uf, input logic [35:0] expv);
        @(negedge clk);
        aclken   = 1'b1;
        tvalid   = 1'b1;
        op_a     = a;
        reci     = r;
        reci_dbz = dbz;
        reci_uf  = uf;
        {cur_flg, cur_res} = expv;
    endtask

    task automatic send_rand(input logic en);
        logic [31:0] a;
        logic [31:0] r;
        logic        d;
        logic        u;
        a = rand_a();
        r = rand_r();
        d = ($urandom_range(0, 15) == 0);
        u = ($urandom_range(0, 15) == 0);
        send(a, r, d, u, model(a, r, d, u));
        aclken = en;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            aclken = 1'b1;
            tvalid = 1'b0;
            op_a   = 32'($urandom);
            reci   = 32'($urandom);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed corner cases with hand-derived results.
        send(32'h3F80_0000, 32'h3F00_0000, 1'b0, 1'b0, {4'b0000, 32'h3F00_0000});
        send(32'h40C0_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, {4'b0000, 32'h4000_0000});
        send(32'h7F00_0000, 32'h4000_0000, 1'b0, 1'b0, {4'b1000, 32'h7F80_0000});
        send(32'h0080_0000, 32'h3F00_0000, 1'b0, 1'b0, {4'b0100, 32'h0000_0000});
        send(32'hBF80_0000, 32'h0000_0000, 1'b1, 1'b0, {4'b0010, 32'hFF80_0000});
        send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, {4'b0001, 32'h7FC0_0000});
        send(32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0, {4'b0001, 32'h7FC0_0000});
        send(32'hFF80_0000, 32'h3F80_0000, 1'b0, 1'b0, {4'b0000, 32'hFF80_0000});
        send(32'h4000_0000, 32'hBF80_0000, 1'b0, 1'b1, {4'b0100, 32'h8000_0000});
        send(32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0, {4'b0000, 32'h0000_0000});
        send(32'h7FC0_1234, 32'h3F80_0000, 1'b1, 1'b0, {4'b0001, 32'h7FC0_0000});
        idle(5);

        // Back-to-back stream of 8 with a 2-cycle clock-enable stall mid-stream.
        for (int i = 0; i < 8; i++) begin
            send_rand(1'b1);
            if (i == 3) begin
                send_rand(1'b0);
                send_rand(1'b0);
            end
        end
        idle(5);

        // Reset with two results in flight; clock enable low must not block it.
        send_rand(1'b1);
        send_rand(1'b1);
        @(negedge clk);
        rst    = 1'b1;
        aclken = 1'b0;
        tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        send_rand(1'b1);
        idle(5);

        // Randomized traffic with random valid and clock-enable gaps.
        for (int i = 0; i < 400; i++) begin
            send_rand(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 3) == 0)
                tvalid = 1'b0;
        end
        idle(8);

        @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
